// File: rtl/data_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ctrl_if
// Description : Instruction handshake and datapath-control bundle of the
//               data_ctrl sequencer. Optional macro: DATA_CTRL_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ctrl_if #(
    parameter int REG_AW = 6
) ();
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       pc;
    logic              eq;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic [31:0]       imm_op;
    logic              alu_src;
    logic              alu_ctrl;
    logic              busy;
    logic              illegal;
`ifdef DATA_CTRL_RETIRE_CNT_EN
    logic [31:0]       retired;

    modport master (
        input  instr, instr_valid, eq,
        output instr_ready, pc, rs1, rs2, rd, reg_write, imm_op,
               alu_src, alu_ctrl, busy, illegal, retired
    );
    modport slave (
        output instr, instr_valid, eq,
        input  instr_ready, pc, rs1, rs2, rd, reg_write, imm_op,
               alu_src, alu_ctrl, busy, illegal, retired
    );
`else
    modport master (
        input  instr, instr_valid, eq,
        output instr_ready, pc, rs1, rs2, rd, reg_write, imm_op,
               alu_src, alu_ctrl, busy, illegal
    );
    modport slave (
        output instr, instr_valid, eq,
        input  instr_ready, pc, rs1, rs2, rd, reg_write, imm_op,
               alu_src, alu_ctrl, busy, illegal
    );
`endif
endinterface
`default_nettype wire

// File: rtl/data_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_ctrl
// Description : FETCH/DECODE/EXEC/WB sequencer for ADD, ADDI and BNE with
//               PC tracking and a sticky trap on unsupported encodings.
//               Optional retire counter: define DATA_CTRL_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          REG_AW   = 6
) (
    input  wire logic     clk,
    input  wire logic     rst,
    data_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    localparam logic [6:0] c_OP_REG = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_BR  = 7'b1100011;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_instr;
    logic [31:0]       r_pc;
    logic [31:0]       r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic              r_is_bne;
    logic              r_reg_write;
    logic              r_alu_src;
    logic              r_alu_ctrl;
    logic              r_illegal;

    logic              w_dec_add;
    logic              w_dec_addi;
    logic              w_dec_bne;
    logic              w_dec_legal;
    logic [31:0]       w_imm_i;
    logic [31:0]       w_imm_b;
    logic [31:0]       w_dec_imm;

    // Decode always looks at the latched word, never the live bus.
    assign w_dec_add   = (r_instr[6:0] == c_OP_REG) && (r_instr[14:12] == 3'b000)
                         && (r_instr[31:25] == 7'b0000000);
    assign w_dec_addi  = (r_instr[6:0] == c_OP_IMM) && (r_instr[14:12] == 3'b000);
    assign w_dec_bne   = (r_instr[6:0] == c_OP_BR)  && (r_instr[14:12] == 3'b001);
    assign w_dec_legal = w_dec_add || w_dec_addi || w_dec_bne;

    assign w_imm_i   = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_b   = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                        r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_dec_imm = w_dec_addi ? w_imm_i : (w_dec_bne ? w_imm_b : 32'h0000_0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  if (bus.instr_valid) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_dec_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_state_nxt = r_is_bne ? S_FETCH : S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_TRAP:   w_state_nxt = S_TRAP;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= 32'h0000_0000;
            r_pc        <= RESET_PC;
            r_imm       <= 32'h0000_0000;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_is_bne    <= 1'b0;
            r_reg_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_ctrl  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.instr_valid) r_instr <= bus.instr;
                end
                S_DECODE: begin
                    r_rs1      <= REG_AW'(r_instr[19:15]);
                    r_rs2      <= REG_AW'(r_instr[24:20]);
                    r_rd       <= REG_AW'(r_instr[11:7]);
                    r_imm      <= w_dec_imm;
                    r_is_bne   <= w_dec_bne;
                    r_alu_src  <= w_dec_addi;
                    r_alu_ctrl <= w_dec_bne;
                    if (!w_dec_legal) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    if (r_is_bne) begin
                        r_pc       <= bus.eq ? (r_pc + 32'd4) : (r_pc + r_imm);
                        r_alu_src  <= 1'b0;
                        r_alu_ctrl <= 1'b0;
                    end else begin
                        // x0 is hardwired; its write strobe never leaves the block.
                        r_reg_write <= (r_rd != '0);
                    end
                end
                S_WB: begin
                    r_reg_write <= 1'b0;
                    r_pc        <= r_pc + 32'd4;
                    r_alu_src   <= 1'b0;
                    r_alu_ctrl  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DATA_CTRL_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= 32'h0000_0000;
        end else if ((r_state == S_WB) || ((r_state == S_EXEC) && r_is_bne)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign bus.retired = r_retired;
`endif

    assign bus.instr_ready = (r_state == S_FETCH);
    assign bus.busy        = (r_state != S_FETCH) && (r_state != S_TRAP);
    assign bus.pc          = r_pc;
    assign bus.rs1         = r_rs1;
    assign bus.rs2         = r_rs2;
    assign bus.rd          = r_rd;
    assign bus.reg_write   = r_reg_write;
    assign bus.imm_op      = r_imm;
    assign bus.alu_src     = r_alu_src;
    assign bus.alu_ctrl    = r_alu_ctrl;
    assign bus.illegal     = r_illegal;

endmodule
`default_nettype wire

// File: doc/data_ctrl.md
# data_ctrl

Multi-cycle sequencer for the register-file/ALU datapath. It accepts 32-bit RV32I instructions over a valid/ready handshake and decodes the supported subset (ADD, ADDI, BNE). It then drives the datapath controls (register addresses, write enable, immediate, operand select, ALU op) through a fixed FETCH→DECODE→EXEC→WB sequence. The block maintains the program counter and traps on unsupported encodings.

## Interface
- `RESET_PC`, 32'h0000_0000: program-counter value after reset.
- `REG_AW`, 6: register address width driven to the datapath; bits above [4] are always 0.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `instr`  in  32  instruction word; valid when `instr_valid` is high.
- `instr_valid`  in  1  source holds a valid instruction.
- `instr_ready`  out  1  sequencer accepts `instr` this cycle.
- `pc`  out  32  address of the instruction being requested or executed.
- `eq`  in  1  ALU equality flag from the datapath.
- `rs1`  out  REG_AW  register-file read address 1.
- `rs2`  out  REG_AW  register-file read address 2.
- `rd`  out  REG_AW  register-file write address.
- `reg_write`  out  1  register-file write enable, one cycle wide.
- `imm_op`  out  32  sign-extended immediate.
- `alu_src`  out  1  0 selects rs2 data, 1 selects `imm_op`.
- `alu_ctrl`  out  1  0 = add, 1 = subtract/compare.
- `busy`  out  1  high in every state except FETCH and TRAP.
- `illegal`  out  1  sticky; set on an unsupported instruction.

## Operation
- States: FETCH, DECODE, EXEC, WB, TRAP.
- **FETCH**
  - `instr_ready=1`.
  - On `instr_valid && instr_ready`, latch `instr` and go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - Classify the latched word:
    - ADD: opcode 0110011, funct3 000, funct7 0000000.
    - ADDI: opcode 0010011, funct3 000.
    - BNE: opcode 1100011, funct3 001.
  - Register `rs1`, `rs2`, `rd` from instr[19:15], [24:20], [11:7], zero-extended to REG_AW.
  - Register `imm_op`: I-immediate for ADDI; B-immediate (bit 0 = 0) for BNE; 0 for ADD.
  - Supported instruction: go to EXEC. Any other encoding: set `illegal` and go to TRAP.
- **EXEC**
  - Drive `alu_src`: 1 for ADDI, 0 otherwise.
  - Drive `alu_ctrl`: 1 for BNE, 0 otherwise.
  - ADD/ADDI: go to WB.
  - BNE: sample `eq` in this cycle.
    - `eq=0`: `pc <= pc + imm_op`.
    - `eq=1`: `pc <= pc + 4`.
    - Next state: FETCH.
- **WB**
  - `reg_write=1` for exactly one cycle, but only if `rd != 0`; writes to x0 are suppressed.
  - `pc <= pc + 4`; next state FETCH.
- **TRAP**
  - Terminal state; left only by `rst`.
  - `instr_ready=0`, `reg_write=0`, `pc` frozen.
- **Arithmetic and hold rules**
  - PC arithmetic is 32-bit modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is legal.
  - `rs1`, `rs2`, `rd`, `imm_op` hold their values from DECODE through WB.

## Timing
- **Reset values:** state FETCH, `pc=RESET_PC`; `rs1`, `rs2`, `rd`, `imm_op`, `alu_src`, `alu_ctrl`, `reg_write`, `illegal`, `busy` all 0; `instr_ready=1` in the first cycle after reset.
- **Latency:**
  - ADD/ADDI: 4 cycles from handshake to the next FETCH (FETCH, DECODE, EXEC, WB).
  - BNE: 3 cycles.
- **Handshake:**
  - `instr_ready` is combinational from state only; it never depends on `instr_valid`.
  - The source must hold `instr` stable while `instr_valid=1 && instr_ready=0`.
- **Datapath timing:**
  - `reg_write` is registered and asserted in the WB cycle.
  - The datapath captures the write-back data on the rising edge that ends WB.
- **`eq`:** sampled only in EXEC of a BNE; ignored in every other cycle.
- **Reset mid-operation:** `rst` asserted in any state returns to FETCH on the next edge. A pending write-back is dropped: `reg_write` is 0 in the cycle after reset.
- **Simultaneous `rst` and handshake:** `rst` wins and the instruction is not latched.

## Configuration
- `DATA_CTRL_RETIRE_CNT_EN`
  - Defined: adds output `retired` (32 bits, reset 0).
    - Increments by 1 on leaving WB, and on leaving EXEC for BNE.
    - Wraps modulo 2^32.
    - Never increments in TRAP.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- **ADDI:** reset, present `instr` 32'h0050_0093 (addi x1,x0,5) → `rs1=0`, `rd=1`, `imm_op=5`, `alu_src=1` in EXEC; `reg_write=1` exactly in cycle 4; `pc=4` afterwards.
- **ADD to x0:** 32'h0020_8033 (add x0,x1,x2) → `rs1=1`, `rs2=2`, `alu_src=0`; `reg_write` stays 0 in WB; `pc` advances by 4.
- **BNE taken:** 32'hFE20_9EE3 (bne x1,x2,-4) at `pc=8`, `eq=0` in EXEC → `alu_ctrl=1`; `pc=4`; back in FETCH after 3 cycles. Same instruction with `eq=1` → `pc=12`.
- **Illegal instruction:** 32'h0000_0073 (ecall) → `illegal=1` after DECODE; `instr_ready=0` for 20+ cycles; `pc` unchanged. Asserting `rst` → `illegal=0`, `pc=RESET_PC`.
- **Reset and handshake stall:** assert `rst` during WB → `reg_write=0` on the next cycle, state FETCH. Hold `instr_valid=0` for 10 cycles → `busy=0`, `pc` stable.
- **Counter (with `DATA_CTRL_RETIRE_CNT_EN`):** 3 ADDI + 2 BNE → `retired=5`. `pc` wrap test: RESET_PC 32'hFFFF_FFFC, one ADDI → `pc=0`.
